// File: rtl/vball_mixer_pkg.sv
// vball_mixer_pkg
// Shared definitions for the VBall final compositing stage: mixer FSM state
// encoding, default line width, sprite palette bank and the transparent
// sprite index.
package vball_mixer_pkg;

  localparam int unsigned LINE_W       = 256;
  localparam logic [2:0]  SPR_PAL_BANK = 3'b100;
  localparam logic [3:0]  SPR_TRANSP   = 4'd0;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD,
    LAT,
    WAIT,
    OUT
  } mix_state_t;

endpackage

// File: rtl/vball_linebuf_bank.sv
// vball_linebuf_bank
// One bank of the sprite line buffer: single-port LINE_W x 7 RAM with a
// synchronous, read-first read port (1-cycle latency).
// Ports:
//   clk_sys  - system clock
//   we       - write enable
//   addr     - shared read/write address
//   wdata    - write data {palette[2:0], index[3:0]}
//   rdata    - registered read data, valid the cycle after addr
module vball_linebuf_bank #(
  parameter int unsigned LINE_W = vball_mixer_pkg::LINE_W,
  parameter int unsigned AW     = 8
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [6:0]    wdata,
  output logic [6:0]    rdata
);

  logic [6:0] mem [LINE_W];

  always_ff @(posedge clk_sys) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vball_mixer.sv
// vball_mixer
// Final per-pixel compositing stage of the VBall video path. Owns a ping-pong
// sprite line buffer (one bank displayed, the other filled by the sprite
// engine), looks sprite pixels up in the sprite palette and outputs blanked
// 12-bit RGB.
// Ports:
//   clk_sys, reset          - clock, synchronous active-high reset
//   hcount, vcount, hb, vb  - video timing; any hcount change is a pixel event
//   bg_red/green/blue       - background layer RGB
//   spr_wr, spr_x, spr_pix  - sprite pixel write port
//   spr_col_addr/data       - sprite palette lookup (1-cycle read latency)
//   red, green, blue        - composited output
//   busy                    - post-reset clear sweep in progress
module vball_mixer #(
  parameter int unsigned LINE_W  = vball_mixer_pkg::LINE_W,
  parameter int unsigned OUT_DLY = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  input  logic        hb,
  input  logic        vb,
  input  logic [3:0]  bg_red,
  input  logic [3:0]  bg_green,
  input  logic [3:0]  bg_blue,
  input  logic        spr_wr,
  input  logic [8:0]  spr_x,
  input  logic [6:0]  spr_pix,
  output logic [9:0]  spr_col_addr,
  input  logic [11:0] spr_col_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        busy
);

  import vball_mixer_pkg::*;

  localparam int unsigned   AW       = $clog2(LINE_W);
  localparam logic [3:0]    DLY      = 4'(OUT_DLY);
  localparam logic [AW-1:0] CLR_LAST = AW'(LINE_W - 1);

  mix_state_t    state, state_nx;
  logic [8:0]    hcount_q;
  logic [AW-1:0] px_addr;
  logic [AW-1:0] clr_addr;
  logic          rd_bank;
  logic          blank_q;
  logic [3:0]    spr_idx_q;
  logic [3:0]    dly_cnt;
  logic          pix_evt;
  logic          wr_ok;
  logic [6:0]    rd_data;

  logic [1:0]    bank_we;
  logic [AW-1:0] bank_addr  [2];
  logic [6:0]    bank_wdata [2];
  logic [6:0]    bank_rdata [2];

  logic          vcount_unused;
  assign vcount_unused = ^vcount;

  assign busy    = (state == CLEAR);
  assign pix_evt = (hcount != hcount_q);
  assign wr_ok   = spr_wr & ~spr_x[8] & (spr_pix[3:0] != SPR_TRANSP) & ~busy;
  assign rd_data = bank_rdata[rd_bank];

  // Each bank port serves either the display reader (read, then clear the
  // same address in LAT) or the sprite writer, selected by rd_bank. The
  // clear sweep owns both ports.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      bank_we[b]    = 1'b0;
      bank_addr[b]  = spr_x[AW-1:0];
      bank_wdata[b] = spr_pix;
      if (state == CLEAR) begin
        bank_we[b]    = 1'b1;
        bank_addr[b]  = clr_addr;
        bank_wdata[b] = '0;
      end else if (1'(b) == rd_bank) begin
        bank_we[b]    = (state == LAT);
        bank_addr[b]  = px_addr;
        bank_wdata[b] = '0;
      end else begin
        bank_we[b]    = wr_ok;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    vball_linebuf_bank #(
      .LINE_W (LINE_W),
      .AW     (AW)
    ) u_bank (
      .clk_sys (clk_sys),
      .we      (bank_we[g]),
      .addr    (bank_addr[g]),
      .wdata   (bank_wdata[g]),
      .rdata   (bank_rdata[g])
    );
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR:   if (clr_addr == CLR_LAST) state_nx = IDLE;
      IDLE:    if (pix_evt) state_nx = RD;
      RD:      state_nx = LAT;
      LAT:     state_nx = WAIT;
      // dly_cnt is the cycle offset from the event; >= keeps short delays safe.
      WAIT:    if (dly_cnt >= DLY - 4'd1) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= CLEAR;
      hcount_q     <= '0;
      clr_addr     <= '0;
      rd_bank      <= 1'b0;
      px_addr      <= '0;
      blank_q      <= 1'b0;
      spr_idx_q    <= '0;
      dly_cnt      <= '0;
      spr_col_addr <= '0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
    end else begin
      state    <= state_nx;
      hcount_q <= hcount;

      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end

      if (state == IDLE && pix_evt) begin
        px_addr <= hcount[AW-1:0];
        blank_q <= hb | vb;
        dly_cnt <= 4'd1;
        if (hcount == '0) begin
          rd_bank <= ~rd_bank;
        end
      end else if (dly_cnt != DLY) begin
        dly_cnt <= dly_cnt + 4'd1;
      end

      if (state == LAT) begin
        spr_idx_q    <= rd_data[3:0];
        spr_col_addr <= {SPR_PAL_BANK, rd_data};
      end

      if (state == OUT) begin
        if (blank_q) begin
          {red, green, blue} <= '0;
        end else if (spr_idx_q != SPR_TRANSP) begin
          {red, green, blue} <= spr_col_data;
        end else begin
          {red, green, blue} <= {bg_red, bg_green, bg_blue};
        end
      end
    end
  end

endmodule

// File: tb/tb_vball_mixer.sv
// tb_vball_mixer
// Self-checking bench for vball_mixer: directed scenarios plus randomized
// lines, all checked against a line-buffer model kept as plain arrays.
module tb_vball_mixer;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [8:0]  hcount  = '0;
  logic [8:0]  vcount  = '0;
  logic        hb      = 1'b0;
  logic        vb      = 1'b0;
  logic [3:0]  bg_red  = '0;
  logic [3:0]  bg_green = '0;
  logic [3:0]  bg_blue = '0;
  logic        spr_wr  = 1'b0;
  logic [8:0]  spr_x   = '0;
  logic [6:0]  spr_pix = '0;
  logic [9:0]  spr_col_addr;
  logic [11:0] spr_col_data = '0;
  logic [3:0]  red, green, blue;
  logic        busy;

  vball_mixer #(
    .LINE_W  (256),
    .OUT_DLY (15)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .hb           (hb),
    .vb           (vb),
    .bg_red       (bg_red),
    .bg_green     (bg_green),
    .bg_blue      (bg_blue),
    .spr_wr       (spr_wr),
    .spr_x        (spr_x),
    .spr_pix      (spr_pix),
    .spr_col_addr (spr_col_addr),
    .spr_col_data (spr_col_data),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [11:0] pal(input logic [9:0] a);
    if (a == 10'h225) return 12'hF0A;
    return 12'(a * 10'd157) ^ 12'h3C5;
  endfunction

  // Sprite palette ROM with 1-cycle read latency.
  always @(posedge clk_sys) spr_col_data <= pal(spr_col_addr);

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: two banks, displayed bank index, busy flag, output.
  logic [6:0]  m_bank [2][256];
  int          m_rd;
  logic        m_busy;
  logic [11:0] m_rgb;
  logic [11:0] m_exp;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
    cyc += n;
  endtask

  task automatic wr(input logic [8:0] x, input logic [6:0] pix);
    spr_wr  = 1'b1;
    spr_x   = x;
    spr_pix = pix;
    if (!x[8] && pix[3:0] != 4'd0 && !m_busy) m_bank[m_rd ^ 1][x[7:0]] = pix;
    step(1);
    spr_wr = 1'b0;
  endtask

  task automatic rand_wr(input int n);
    logic [8:0] x;
    for (int i = 0; i < n; i++) begin
      x = {($urandom_range(0, 7) == 0), 8'($urandom_range(0, 31))};
      wr(x, 7'($urandom));
    end
  endtask

  task automatic pixel_start(input logic [8:0] h, input logic hbv, input logic vbv,
                             input logic [11:0] bg);
    logic [6:0] v;
    hcount = h;
    hb     = hbv;
    vb     = vbv;
    {bg_red, bg_green, bg_blue} = bg;
    cyc = 0;
    if (h == 9'd0) m_rd ^= 1;
    v = m_bank[m_rd][h[7:0]];
    m_bank[m_rd][h[7:0]] = '0;
    if (hbv || vbv)          m_exp = '0;
    else if (v[3:0] != 4'd0) m_exp = pal({3'b100, v});
    else                     m_exp = bg;
  endtask

  task automatic pixel_hold();
    step(13 - cyc);
    check("hold", {20'd0, red, green, blue}, {20'd0, m_rgb});
  endtask

  task automatic pixel_end(input string tag);
    step(24 - cyc);
    check(tag, {20'd0, red, green, blue}, {20'd0, m_exp});
    m_rgb = m_exp;
  endtask

  task automatic pixel(input logic [8:0] h, input logic hbv, input logic vbv,
                       input logic [11:0] bg, input int nrand, input string tag);
    pixel_start(h, hbv, vbv, bg);
    pixel_hold();
    rand_wr(nrand);
    pixel_end(tag);
  endtask

  // Entered on the first cycle after the last reset edge.
  task automatic clear_phase(input bit with_writes);
    cyc = 0;
    check("busy_start", {31'd0, busy}, 32'd1);
    check("rgb_reset", {20'd0, red, green, blue}, 32'd0);
    check("col_addr_reset", {22'd0, spr_col_addr}, 32'd0);
    if (with_writes) begin
      wr(9'd15, 7'h1F);
      wr(9'd16, 7'h2E);
      wr(9'd10, 7'h33);
    end
    step(255 - cyc);
    check("busy_last", {31'd0, busy}, 32'd1);
    check("rgb_clear", {20'd0, red, green, blue}, 32'd0);
    step(1);
    check("busy_end", {31'd0, busy}, 32'd0);
    m_busy = 1'b0;
  endtask

  task automatic do_reset(input bit with_writes);
    reset = 1'b1;
    step(1);
    check("rgb_in_reset", {20'd0, red, green, blue}, 32'd0);
    step(1);
    reset = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) m_bank[b][a] = '0;
    m_rd   = 0;
    m_rgb  = '0;
    m_busy = 1'b1;
    clear_phase(with_writes);
  endtask

  initial begin
    logic [8:0] h;
    m_busy = 1'b1;
    m_rd   = 0;
    m_rgb  = '0;
    do_reset(1'b1);

    // Line A: fill the write bank.
    pixel(9'h150, 1'b1, 1'b0, 12'h777, 0, "pre");
    pixel_start(9'd0, 1'b0, 1'b0, 12'h456);
    pixel_hold();
    wr(9'd10,  7'h25);
    wr(9'd20,  7'h30);
    wr(9'd20,  7'h11);
    wr(9'd20,  7'h12);
    wr(9'd5,   7'h17);
    wr(9'h105, 7'h49);
    wr(9'd6,   7'h1A);
    pixel_end("lineA_x0");
    pixel(9'h140, 1'b1, 1'b0, 12'h777, 0, "hb_gap");

    // Line B: display what line A wrote.
    vcount = 9'd1;
    pixel(9'd0,  1'b0, 1'b0, 12'h321, 0, "lineB_x0");
    pixel(9'd10, 1'b0, 1'b0, 12'h123, 0, "sprite_x10");
    pixel(9'd11, 1'b0, 1'b0, 12'h123, 0, "bg_x11");
    pixel(9'd20, 1'b0, 1'b0, 12'h123, 0, "last_wins");
    pixel(9'd5,  1'b0, 1'b0, 12'h0F0, 0, "x5_dropped_hi");
    pixel(9'd6,  1'b0, 1'b1, 12'h0F0, 0, "vblank");
    pixel(9'd15, 1'b0, 1'b0, 12'hABC, 0, "busy_wr");
    pixel(9'h1F0, 1'b1, 1'b0, 12'h777, 0, "hb_gap");

    // Line C: other bank, writes x=12 for line D.
    vcount = 9'd2;
    pixel_start(9'd0, 1'b0, 1'b0, 12'h654);
    pixel_hold();
    wr(9'd12, 7'h2B);
    pixel_end("lineC_x0");
    pixel(9'd5,  1'b0, 1'b0, 12'h0F0, 0, "lineC_x5");
    pixel(9'd16, 1'b0, 1'b0, 12'hABC, 0, "busy_wr2");
    pixel(9'h1F0, 1'b1, 1'b0, 12'h777, 0, "hb_gap");

    // Line D: same bank as line B, already cleared by readout.
    vcount = 9'd3;
    pixel(9'd0,  1'b0, 1'b0, 12'h111, 0, "lineD_x0");
    pixel(9'd5,  1'b0, 1'b0, 12'h2D2, 0, "clear_after_read");
    pixel(9'd10, 1'b0, 1'b0, 12'h2D2, 0, "clear_x10");
    pixel(9'd12, 1'b1, 1'b0, 12'h2D2, 0, "hblank");
    pixel(9'h1F0, 1'b1, 1'b0, 12'h777, 0, "hb_gap");

    // Randomized lines.
    for (int l = 0; l < 10; l++) begin
      vcount = 9'(4 + l);
      pixel(9'd0, 1'b0, 1'b0, 12'($urandom), $urandom_range(0, 3), "rnd_x0");
      for (int k = 0; k < 7; k++) begin
        h = 9'($urandom_range(0, 31));
        while (h == hcount) h = 9'($urandom_range(0, 31));
        pixel(h, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              12'($urandom), $urandom_range(0, 3), "rnd");
      end
      pixel({1'b1, 8'($urandom)}, 1'b1, 1'b0, 12'($urandom), $urandom_range(0, 3), "rnd_hb");
    end

    // Reset in the middle of a sprite pixel.
    pixel_start(9'd0, 1'b0, 1'b0, 12'h135);
    pixel_hold();
    wr(9'd7, 7'h3C);
    pixel_end("pre_rst_x0");
    pixel(9'h1F0, 1'b1, 1'b0, 12'h777, 0, "hb_gap");
    pixel(9'd0, 1'b0, 1'b0, 12'h246, 0, "pre_rst_x0b");
    pixel_start(9'd7, 1'b0, 1'b0, 12'h246);
    step(8);
    do_reset(1'b0);
    pixel(9'd0,  1'b0, 1'b0, 12'h5A5, 0, "post_rst_x0");
    pixel(9'd7,  1'b0, 1'b0, 12'h5A5, 0, "post_rst_x7");
    pixel(9'h1F0, 1'b1, 1'b0, 12'h777, 0, "hb_gap");
    pixel(9'd0,  1'b0, 1'b0, 12'hA5A, 0, "post_rst_x0b");
    pixel(9'd7,  1'b0, 1'b0, 12'hA5A, 0, "post_rst_x7b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vball_mixer.md
# vball_mixer

Final per-pixel compositing stage of the VBall video path. Consumes the background layer's 12-bit RGB, owns a ping-pong sprite line buffer that the sprite engine fills one line ahead, looks sprite indices up in the sprite palette, and outputs blanked 4:4:4 RGB to the video output.

## Interface
Parameters:
- `LINE_W`, default 256: visible pixels per line; line-buffer depth per bank, indexed by `hcount[7:0]`.
- `OUT_DLY`, default 15: clk_sys cycles from pixel event to output commit.

Ports:
- `clk_sys` in 1: system clock; only clock.
- `reset` in 1: synchronous, active-high.
- `hcount` in 9: current pixel x; any change is a pixel event.
- `vcount` in 9: current line; informational only.
- `hb` in 1: horizontal blank.
- `vb` in 1: vertical blank.
- `bg_red`, `bg_green`, `bg_blue` in 4 each: background RGB; valid from event + 14.
- `spr_wr` in 1: sprite pixel write strobe, one pixel per cycle.
- `spr_x` in 9: sprite pixel x; writes with `spr_x[8]=1` are dropped.
- `spr_pix` in 7: `{palette[2:0], index[3:0]}`; `index=0` is transparent and dropped.
- `spr_col_addr` out 10: sprite palette address `{3'b100, spr_pix}`.
- `spr_col_data` in 12: palette RGB, 1-cycle read latency.
- `red`, `green`, `blue` out 4 each: composited output.
- `busy` out 1: high during the post-reset clear sweep.

## Operation
- Two banks of `LINE_W` x 7 bits. `rd_bank` is displayed; `~rd_bank` accepts sprite writes.
- Bank swap happens on the pixel event whose new `hcount` equals 0. `rd_bank` toggles in the event cycle, so that event's read uses the new bank.
- Writes:
  - Accepted when `spr_wr & ~spr_x[8] & (spr_pix[3:0]!=0) & ~busy`; stored at `spr_x[7:0]` of the write bank.
  - Last write wins; the sprite engine orders writes lowest priority first.
- Readout is clear-after-read: the address just read in the read bank is written to 0 one cycle later. The bank is therefore empty by the time it becomes the write bank.
- A clear write and a sprite write never collide, because they target different banks.
- FSM states:
  - CLEAR: entered on reset. Sweeps addresses 0..`LINE_W`-1 in both banks at once, one per cycle, writing 0. `busy`=1 and outputs 0. Then goes to IDLE.
  - IDLE: waits for `hcount != hcount_q`. On the event, latch `hcount[7:0]` and `blank_q = hb|vb`, then go to RD.
  - RD: read line buffer, go to LAT.
  - LAT: register `spr_q`, drive `spr_col_addr`, write 0 to the read address, go to WAIT.
  - WAIT: counter runs until event + `OUT_DLY` - 1, then go to OUT.
  - OUT: commit output, go to IDLE.
- Output selection at commit:
  - `blank_q`: 0.
  - else `spr_q[3:0]!=0`: `spr_col_data`.
  - else: `{bg_red, bg_green, bg_blue}`.
- A pixel event that arrives in any state other than IDLE is missed. This is a system-level error; the pixel period must be at least `OUT_DLY`+1 = 16 clk_sys cycles.

## Timing
- Event cycle E is the first cycle with `hcount != hcount_q`.
- RD at E+1, LAT at E+2, clear write at E+2, `spr_col_data` valid at E+3.
- Output registers update at E+`OUT_DLY` and hold until the next commit.
- Reset values: `red`/`green`/`blue`=0, `spr_col_addr`=0, `rd_bank`=0, `hcount_q`=0, `busy`=1 from the cycle after `reset` for exactly `LINE_W` cycles.
- Reset mid-operation aborts any in-flight pixel. No commit occurs until CLEAR completes; the first event after that is processed normally.
- Line-buffer RAMs: single-port, synchronous read, 1-cycle latency, inferred in block RAM. Each bank port is muxed between writer and reader according to `rd_bank`.
- Width rules:
  - `spr_x[8]` gates the write; only `[7:0]` addresses.
  - The wait counter is 4 bits, saturating at `OUT_DLY`.

## Structure
- Shared package: state encoding (`CLEAR`, `IDLE`, `RD`, `LAT`, `WAIT`, `OUT`), `LINE_W`, sprite palette bank constant `3'b100`, transparent index `4'd0`.
- One sub-module: `vball_linebuf_bank` (single-port `LINE_W`x7 RAM with write-enable), instantiated twice.
- Mixer FSM, write steering and output mux stay in the top level.

## Test plan
- Reset then idle: `busy` high for 256 cycles, then low; RGB = 0 throughout; writes during `busy` leave no trace on the next two lines.
- Line N: write x=10 `spr_pix`=7'h25, palette[0x225]=12'hF0A, bg=12'h123. Line N+1, x=10 → RGB 12'hF0A at E+15; x=11 → 12'h123.
- Transparency and last-wins: x=20 gets 7'h30 (dropped) then 7'h11 then 7'h12 → line N+1 shows palette[0x212] at x=20.
- Clear-after-read: sprite at x=5 shown on line N+1; with no new writes, line N+3 (same bank) shows bg at x=5.
- Blanking: `hb`=1 or `vb`=1 at event, with sprite present → RGB 0; `spr_x`=9'h105 write is dropped and x=5 is unaffected.
- `reset` asserted at E+8 of a sprite pixel → no commit for that pixel, RGB 0, CLEAR sweep restarts, stored sprites gone.
